// File: rtl/cordic_z_sequencer.sv
// cordic_z_sequencer
// ------------------
// Control FSM for one expanded-hyperbolic CORDIC exponential operation.
// The FSM steps through four states: IDLE, LOAD, ITER (N_ITER cycles) and DONE.
// It drives the Z angle ROM and strobes the X/Y/Z iteration datapath.
// The ROM has a one-cycle registered read, so the address runs one step ahead
// of the iteration being applied. The ROM word consumed in iteration k was
// therefore addressed (ADRS=k) in the cycle before.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   START     in   operation request, accepted only while READY=1
//   ABORT     in   kills an operation in LOAD/ITER, ignored elsewhere
//   ACK       in   acknowledges DONE, ignored outside DONE
//   READY     out  idle, START will be accepted
//   BUSY      out  LOAD or ITER in progress
//   LOAD_REGS out  one-cycle strobe: datapath latches operands
//   EN_ROM1   out  Z-ROM read enable
//   ADRS      out  Z-ROM address
//   ITER_EN   out  datapath applies one iteration this cycle
//   ITER_IDX  out  index of the iteration being applied
//   NEG_ITER  out  ITER_IDX < M_NEG (expanded-range iteration)
//   DONE      out  result valid, held until ACK
// All outputs are registered.

module cordic_z_sequencer #(
  parameter int D      = 5,
  parameter int N_ITER = 32,
  parameter int M_NEG  = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic         ACK,
  output logic         READY,
  output logic         BUSY,
  output logic         LOAD_REGS,
  output logic         EN_ROM1,
  output logic [D-1:0] ADRS,
  output logic         ITER_EN,
  output logic [D-1:0] ITER_IDX,
  output logic         NEG_ITER,
  output logic         DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index of the last iteration. It also bounds ADRS, so the address never wraps.
  localparam logic [D-1:0] LAST_C = D'(N_ITER - 1);
  localparam logic [D-1:0] ZERO_C = '0;
  localparam logic [D-1:0] ONE_C  = D'(1);

  state_t       state_r;
  logic [D-1:0] k_r;
  logic [D-1:0] k_next_s;

  // Expanded-range select for iteration index k.
  function automatic logic neg_sel(input logic [D-1:0] k);
    neg_sel = (int'(k) < M_NEG);
  endfunction

  // Next iteration index. It is only used when k_r is below LAST_C, so it cannot overflow.
  always_comb begin
    k_next_s = k_r + ONE_C;
  end

  // Single FSM. Every output is assigned together with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      k_r       <= ZERO_C;
      READY     <= 1'b1;
      BUSY      <= 1'b0;
      LOAD_REGS <= 1'b0;
      EN_ROM1   <= 1'b0;
      ADRS      <= ZERO_C;
      ITER_EN   <= 1'b0;
      ITER_IDX  <= ZERO_C;
      NEG_ITER  <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            // Fetch ROM entry 0 while the datapath latches its operands.
            state_r   <= ST_LOAD;
            READY     <= 1'b0;
            BUSY      <= 1'b1;
            LOAD_REGS <= 1'b1;
            EN_ROM1   <= 1'b1;
            ADRS      <= ZERO_C;
          end
        end

        ST_LOAD: begin
          if (ABORT) begin
            state_r   <= ST_IDLE;
            READY     <= 1'b1;
            BUSY      <= 1'b0;
            LOAD_REGS <= 1'b0;
            EN_ROM1   <= 1'b0;
            ADRS      <= ZERO_C;
          end else begin
            state_r   <= ST_ITER;
            k_r       <= ZERO_C;
            LOAD_REGS <= 1'b0;
            ITER_EN   <= 1'b1;
            ITER_IDX  <= ZERO_C;
            NEG_ITER  <= neg_sel(ZERO_C);
            // With a single iteration there is nothing left to prefetch.
            if (LAST_C == ZERO_C) begin
              EN_ROM1 <= 1'b0;
              ADRS    <= ZERO_C;
            end else begin
              EN_ROM1 <= 1'b1;
              ADRS    <= ONE_C;
            end
          end
        end

        ST_ITER: begin
          if (ABORT) begin
            state_r  <= ST_IDLE;
            k_r      <= ZERO_C;
            READY    <= 1'b1;
            BUSY     <= 1'b0;
            EN_ROM1  <= 1'b0;
            ADRS     <= ZERO_C;
            ITER_EN  <= 1'b0;
            ITER_IDX <= ZERO_C;
            NEG_ITER <= 1'b0;
          end else if (k_r == LAST_C) begin
            // ADRS keeps the last address that was fetched.
            state_r  <= ST_DONE;
            BUSY     <= 1'b0;
            EN_ROM1  <= 1'b0;
            ITER_EN  <= 1'b0;
            NEG_ITER <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            k_r      <= k_next_s;
            ITER_IDX <= k_next_s;
            NEG_ITER <= neg_sel(k_next_s);
            // The final iteration has no successor. ADRS already holds LAST_C.
            if (k_next_s == LAST_C) begin
              EN_ROM1 <= 1'b0;
            end else begin
              EN_ROM1 <= 1'b1;
              ADRS    <= k_next_s + ONE_C;
            end
          end
        end

        ST_DONE: begin
          // START and ABORT are ignored here. Only ACK leaves DONE.
          if (ACK) begin
            state_r  <= ST_IDLE;
            k_r      <= ZERO_C;
            READY    <= 1'b1;
            DONE     <= 1'b0;
            ADRS     <= ZERO_C;
            ITER_IDX <= ZERO_C;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          k_r       <= ZERO_C;
          READY     <= 1'b1;
          BUSY      <= 1'b0;
          LOAD_REGS <= 1'b0;
          EN_ROM1   <= 1'b0;
          ADRS      <= ZERO_C;
          ITER_EN   <= 1'b0;
          ITER_IDX  <= ZERO_C;
          NEG_ITER  <= 1'b0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_z_sequencer.sv
// Directed bench for cordic_z_sequencer.
// dut_a: default parameters.
// dut_c: M_NEG=0, driven in lockstep with dut_a.
// dut_b: N_ITER=1.
// Expected values are hand-derived from the cycle schedule:
//   START sampled           -> LOAD cycle
//   next N_ITER cycles      -> ITER cycles
//   following cycle         -> DONE
// Status flags are packed as {READY,BUSY,LOAD_REGS,EN_ROM1,ITER_EN,NEG_ITER,DONE}.

module tb_cordic_z_sequencer;

  logic CLK = 1'b0;
  logic RST, START, ABORT, ACK;

  logic       ready_a, busy_a, load_a, en_a, iter_a, neg_a, done_a;
  logic [4:0] adrs_a, idx_a;
  logic       ready_b, busy_b, load_b, en_b, iter_b, neg_b, done_b;
  logic [4:0] adrs_b, idx_b;
  logic       ready_c, busy_c, load_c, en_c, iter_c, neg_c, done_c;
  logic [4:0] adrs_c, idx_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  cordic_z_sequencer #(.D(5), .N_ITER(32), .M_NEG(7)) dut_a (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ACK(ACK),
    .READY(ready_a), .BUSY(busy_a), .LOAD_REGS(load_a), .EN_ROM1(en_a),
    .ADRS(adrs_a), .ITER_EN(iter_a), .ITER_IDX(idx_a), .NEG_ITER(neg_a),
    .DONE(done_a)
  );

  cordic_z_sequencer #(.D(5), .N_ITER(1), .M_NEG(1)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ACK(ACK),
    .READY(ready_b), .BUSY(busy_b), .LOAD_REGS(load_b), .EN_ROM1(en_b),
    .ADRS(adrs_b), .ITER_EN(iter_b), .ITER_IDX(idx_b), .NEG_ITER(neg_b),
    .DONE(done_b)
  );

  cordic_z_sequencer #(.D(5), .N_ITER(32), .M_NEG(0)) dut_c (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ACK(ACK),
    .READY(ready_c), .BUSY(busy_c), .LOAD_REGS(load_c), .EN_ROM1(en_c),
    .ADRS(adrs_c), .ITER_EN(iter_c), .ITER_IDX(idx_c), .NEG_ITER(neg_c),
    .DONE(done_c)
  );

  function automatic logic [6:0] flags_a();
    return {ready_a, busy_a, load_a, en_a, iter_a, neg_a, done_a};
  endfunction

  function automatic logic [6:0] flags_b();
    return {ready_b, busy_b, load_b, en_b, iter_b, neg_b, done_b};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one operation on dut_a/dut_c.
  // abort_at >= 0 kills it during that iteration.
  // Without an abort the task returns in the first DONE cycle.
  task automatic run_op(input int abort_at);
    logic [6:0] exp_f;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_val("load_flags", {25'd0, flags_a()}, {25'd0, 7'b0111000});
    check_val("load_adrs", {27'd0, adrs_a}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      exp_f = {1'b0, 1'b1, 1'b0, (k < 31), 1'b1, (k < 7), 1'b0};
      check_val($sformatf("iter%0d_flags", k), {25'd0, flags_a()}, {25'd0, exp_f});
      check_val($sformatf("iter%0d_idx", k), {27'd0, idx_a}, k);
      check_val($sformatf("iter%0d_adrs", k), {27'd0, adrs_a}, (k < 31) ? k + 1 : 31);
      check_val($sformatf("iter%0d_neg_m0", k), {31'd0, neg_c}, 32'd0);
      if (k == abort_at) begin
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_val("abort_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});
        check_val("abort_adrs", {27'd0, adrs_a}, 32'd0);
        for (int j = 0; j < 40; j++) begin
          tick();
          check_val("abort_no_done", {31'd0, done_a}, 32'd0);
        end
        return;
      end
    end
    tick();
    check_val("done_flags", {25'd0, flags_a()}, {25'd0, 7'b0000001});
  endtask

  initial begin
    int done_seen;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; ACK = 1'b0;

    // Reset, then stay idle.
    tick();
    tick();
    check_val("rst_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});
    check_val("rst_adrs", {27'd0, adrs_a}, 32'd0);
    check_val("rst_idx", {27'd0, idx_a}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_val("idle_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check_val("idle_ack_ignored", {25'd0, flags_a()}, {25'd0, 7'b1000000});

    // Full operation, then hold DONE with stray START/ABORT.
    run_op(-1);
    for (int i = 0; i < 20; i++) begin
      START = (i >= 10) ? 1'b1 : 1'b0;
      ABORT = (i == 5) ? 1'b1 : 1'b0;
      tick();
      check_val($sformatf("hold%0d_flags", i), {25'd0, flags_a()}, {25'd0, 7'b0000001});
    end
    ABORT = 1'b0;
    ACK = 1'b1;  // START is still high: ACK wins, START is not taken.
    tick();
    ACK = 1'b0;
    START = 1'b0;
    check_val("ack_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});
    tick();
    check_val("ack_no_start", {25'd0, flags_a()}, {25'd0, 7'b1000000});

    // Abort at iteration 10, then an immediate full operation.
    run_op(10);
    run_op(-1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check_val("ack2_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});

    // Reset mid-operation at iteration 5.
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k <= 5; k++) tick();
    check_val("pre_rst_idx", {27'd0, idx_a}, 32'd5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("midrst_flags", {25'd0, flags_a()}, {25'd0, 7'b1000000});
    check_val("midrst_adrs", {27'd0, adrs_a}, 32'd0);
    check_val("midrst_idx", {27'd0, idx_a}, 32'd0);
    done_seen = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done_a) done_seen++;
    end
    check_val("midrst_no_done", done_seen, 32'd0);

    // N_ITER=1 corner on dut_b.
    // Reset first so dut_b starts from IDLE.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("b_rst_flags", {25'd0, flags_b()}, {25'd0, 7'b1000000});
    START = 1'b1;
    tick();
    START = 1'b0;
    check_val("b_load_flags", {25'd0, flags_b()}, {25'd0, 7'b0111000});
    tick();
    check_val("b_iter_flags", {25'd0, flags_b()}, {25'd0, 7'b0100110});
    check_val("b_iter_idx", {27'd0, idx_b}, 32'd0);
    check_val("b_iter_adrs", {27'd0, adrs_b}, 32'd0);
    tick();
    check_val("b_done_flags", {25'd0, flags_b()}, {25'd0, 7'b0000001});
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check_val("b_ack_flags", {25'd0, flags_b()}, {25'd0, 7'b1000000});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
